ram_arb: RTL and testbench
==========================

Name: ram_arb

Overview:
- Single-port synchronous RAM arbiter for the hxd32 SoC.
- Shares one unified instruction/data RAM between three requesters: debug/loader port, core data port and core instruction-fetch port.
- Grants are combinational; read data returns one cycle after grant. The core stalls its pipeline on a missing fetch or data grant.
- A lock state machine gives the debug/loader port exclusive access for program load.

Parameters:
- XLEN, 32, data and address width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is promoted above data; legal range >=1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- dbg_req_i  in  1  debug access request
- dbg_addr_i  in  XLEN  debug byte address
- dbg_wr_data_i  in  XLEN  debug write data
- dbg_wr_byte_en_i  in  4  debug byte enables; nonzero = write, zero = read
- dbg_gnt_o  out  1  debug granted this cycle
- dbg_rd_valid_o  out  1  debug read data valid
- dbg_lock_i  in  1  request exclusive debug ownership
- dbg_lock_ack_o  out  1  exclusive ownership held
- data_req_i, data_addr_i, data_wr_data_i, data_wr_byte_en_i, data_gnt_o, data_rd_valid_o  as dbg_*, core data port
- fetch_req_i  in  1  fetch request (read only)
- fetch_addr_i  in  XLEN  fetch address
- fetch_gnt_o  out  1  fetch granted
- fetch_rd_valid_o  out  1  fetch data valid
- rd_data_o  out  XLEN  read data, shared by all requesters; qualify with *_rd_valid_o
- mem_en_o  out  1  RAM access this cycle
- mem_addr_o  out  XLEN  RAM address
- mem_wr_data_o  out  XLEN  RAM write data
- mem_wr_byte_en_o  out  4  RAM byte write enables
- mem_rd_data_i  in  XLEN  RAM read data, 1-cycle latency

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low.
- Reset values:
  - state = RUN, starve_cnt = 0, owner tag = NONE.
  - All *_rd_valid_o = 0, dbg_lock_ack_o = 0.
  - Grants are combinational and gated by req, so they are 0 while requests are low.
  - mem_en_o = 0, mem_wr_byte_en_o = 0.
- Grant rules: at most one grant per cycle. gnt is combinational from req, state and starve_cnt.
- RUN priority is dbg > data > fetch, except when starve_cnt == STARVE_MAX: then dbg > fetch > data.
- DRAIN: no grants.
- LOCKED: only dbg may be granted.
- Memory mux:
  - mem_en_o = OR of grants.
  - mem_addr_o, mem_wr_data_o and mem_wr_byte_en_o come from the granted requester; all zero when there is no grant.
  - Fetch always drives byte_en = 0.
- Read return:
  - A granted access with byte_en == 0 registers an owner tag.
  - Next cycle, that requester's rd_valid_o = 1 for one cycle.
  - rd_data_o = mem_rd_data_i combinationally.
  - Writes produce no rd_valid.
  - Back-to-back grants pipeline fully, 1 access/cycle.
- Starvation counter:
  - Increments in RUN when fetch_req_i && !fetch_gnt_o, saturating at STARVE_MAX.
  - Clears on fetch_gnt_o or !fetch_req_i.
  - Holds in DRAIN and LOCKED.
- Lock FSM (registered transitions):
  - RUN -> DRAIN when dbg_lock_i. The current cycle still arbitrates normally.
  - DRAIN -> LOCKED if dbg_lock_i, else -> RUN. DRAIN lasts exactly one cycle, which lets the outstanding read return.
  - LOCKED -> RUN when !dbg_lock_i.
  - dbg_lock_ack_o = (state == LOCKED), registered.
- Boundary cases:
  - dbg_lock_i dropping in the same cycle as a dbg access in LOCKED: the access is still granted, and the state returns to RUN next cycle.
  - Requester changes address while not granted: no effect. The requester must hold its request until granted.
  - Reset mid-read: rd_valid is suppressed.
  - All requests low: mem_en_o = 0, no state change except starve_cnt clearing.

Decomposition:
- Package hxd32_pkg gains:
  - typedef enum logic [1:0] {RUN, DRAIN, LOCKED} arb_state_t;
  - typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_DATA, OWN_FETCH} arb_owner_t.
- One natural sub-module: arb_prio, the combinational priority encoder taking reqs, state and starve flag and producing the one-hot grant.
- FSM, counter and return path stay in ram_arb.

Test Plan:
- Reset release, all req = 0 -> all gnt/rd_valid = 0, mem_en_o = 0, dbg_lock_ack_o = 0.
- fetch_req_i = 1, addr 0x100, RAM returns 0x00000013 -> fetch_gnt_o same cycle; next cycle fetch_rd_valid_o = 1, rd_data_o = 0x00000013.
- data write addr 0x2000, data 0xDEADBEEF, byte_en 4'b0011, with simultaneous fetch req -> data granted, mem_wr_byte_en_o = 4'b0011, fetch denied; no rd_valid follows.
- data_req and fetch_req held high continuously, STARVE_MAX = 4 -> data granted cycles 0–3, fetch granted cycle 4, counter cleared, then data again.
- Lock sequence:
  - Stimulus: dbg_lock_i = 1 while fetch streams; then dbg write 0x0 = 0x12345678; then lock drops.
  - Response: one DRAIN cycle with no grants; dbg_lock_ack_o = 1 from the third cycle.
  - While locked: fetch never granted; the dbg write is granted.
  - After lock drops: RUN, and fetch is granted next cycle.
- Assert rst_n_i low one cycle after a data read grant -> data_rd_valid_o stays 0; FSM returns to RUN.

Source files
------------

// File: rtl/hxd32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hxd32_pkg
// Brief    : Shared types and helpers for the hxd32 RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package hxd32_pkg;

  // Lock state of the arbiter.
  typedef enum logic [1:0] {RUN, DRAIN, LOCKED} arb_state_t;

  // Requester that owns the read currently in flight.
  typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_DATA, OWN_FETCH} arb_owner_t;

  // Width of the per-byte write enable bus.
  localparam int C_BE_W = 4;

  // An access is a read when no byte lane is enabled for writing.
  function automatic logic is_read(input logic [C_BE_W-1:0] be);
    return (be == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : arb_prio
// Brief    : Combinational one-hot priority encoder for the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module arb_prio
  import hxd32_pkg::*;
(
  input  logic       dbg_req,
  input  logic       data_req,
  input  logic       fetch_req,
  input  arb_state_t state,
  input  logic       starve,
  output logic       dbg_gnt,
  output logic       data_gnt,
  output logic       fetch_gnt
);

  // Pick at most one requester; a starved fetch jumps ahead of data.
  always_comb begin
    dbg_gnt   = 1'b0;
    data_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    case (state)
      RUN: begin
        if (dbg_req) begin
          dbg_gnt = 1'b1;
        end else if (starve) begin
          if (fetch_req)     fetch_gnt = 1'b1;
          else if (data_req) data_gnt  = 1'b1;
        end else begin
          if (data_req)       data_gnt  = 1'b1;
          else if (fetch_req) fetch_gnt = 1'b1;
        end
      end
      LOCKED: begin
        dbg_gnt = dbg_req;
      end
      default: begin
        // DRAIN leaves the RAM idle so the outstanding read can return.
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb
// Brief    : Single-port RAM arbiter for debug, core data and core fetch
//            ports with a debug lock for exclusive program load.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb
  import hxd32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dbg_req_i,
  input  logic [XLEN-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0]   dbg_wr_data_i,
  input  logic [C_BE_W-1:0] dbg_wr_byte_en_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rd_valid_o,
  input  logic              dbg_lock_i,
  output logic              dbg_lock_ack_o,
  input  logic              data_req_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wr_data_i,
  input  logic [C_BE_W-1:0] data_wr_byte_en_i,
  output logic              data_gnt_o,
  output logic              data_rd_valid_o,
  input  logic              fetch_req_i,
  input  logic [XLEN-1:0]   fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rd_valid_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              mem_en_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  output logic [C_BE_W-1:0] mem_wr_byte_en_o,
  input  logic [XLEN-1:0]   mem_rd_data_i
);

  localparam int C_CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STARVE_MAX);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  arb_owner_t         r_owner;
  arb_owner_t         w_owner_next;
  logic [C_CNT_W-1:0] r_starve_cnt;
  logic               w_starve;
  logic               w_dbg_gnt;
  logic               w_data_gnt;
  logic               w_fetch_gnt;

  assign w_starve = (r_starve_cnt == C_CNT_MAX);

  arb_prio u_prio (
    .dbg_req   (dbg_req_i),
    .data_req  (data_req_i),
    .fetch_req (fetch_req_i),
    .state     (r_state),
    .starve    (w_starve),
    .dbg_gnt   (w_dbg_gnt),
    .data_gnt  (w_data_gnt),
    .fetch_gnt (w_fetch_gnt)
  );

  assign dbg_gnt_o   = w_dbg_gnt;
  assign data_gnt_o  = w_data_gnt;
  assign fetch_gnt_o = w_fetch_gnt;

  // Lock state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  // Lock transitions: RUN -> DRAIN for one cycle, then LOCKED or back to RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (dbg_lock_i) w_state_next = DRAIN;
      DRAIN:   w_state_next = dbg_lock_i ? LOCKED : RUN;
      LOCKED:  if (!dbg_lock_i) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign dbg_lock_ack_o = (r_state == LOCKED);

  // Count denied fetch cycles in RUN; frozen while draining or locked.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve_cnt <= '0;
    end else if (r_state == RUN) begin
      if (fetch_req_i && !w_fetch_gnt) begin
        if (!w_starve) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // Tag the requester whose granted read returns next cycle.
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_dbg_gnt && is_read(dbg_wr_byte_en_i))        w_owner_next = OWN_DBG;
    else if (w_data_gnt && is_read(data_wr_byte_en_i)) w_owner_next = OWN_DATA;
    else if (w_fetch_gnt)                              w_owner_next = OWN_FETCH;
  end

  // Owner tag register; reset drops any read in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_owner <= OWN_NONE;
    else          r_owner <= w_owner_next;
  end

  assign dbg_rd_valid_o   = (r_owner == OWN_DBG);
  assign data_rd_valid_o  = (r_owner == OWN_DATA);
  assign fetch_rd_valid_o = (r_owner == OWN_FETCH);
  assign rd_data_o        = mem_rd_data_i;

  // Route the granted requester onto the RAM port; idle bus is all zero.
  always_comb begin
    mem_en_o         = w_dbg_gnt | w_data_gnt | w_fetch_gnt;
    mem_addr_o       = '0;
    mem_wr_data_o    = '0;
    mem_wr_byte_en_o = '0;
    if (w_dbg_gnt) begin
      mem_addr_o       = dbg_addr_i;
      mem_wr_data_o    = dbg_wr_data_i;
      mem_wr_byte_en_o = dbg_wr_byte_en_i;
    end else if (w_data_gnt) begin
      mem_addr_o       = data_addr_i;
      mem_wr_data_o    = data_wr_data_i;
      mem_wr_byte_en_o = data_wr_byte_en_i;
    end else if (w_fetch_gnt) begin
      mem_addr_o       = fetch_addr_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arb
// Brief    : Directed vector bench for ram_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arb;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        dbg_req_i, data_req_i, fetch_req_i, dbg_lock_i;
  logic [31:0] dbg_addr_i, dbg_wr_data_i, data_addr_i, data_wr_data_i, fetch_addr_i;
  logic [3:0]  dbg_wr_byte_en_i, data_wr_byte_en_i;
  logic        dbg_gnt_o, dbg_rd_valid_o, dbg_lock_ack_o;
  logic        data_gnt_o, data_rd_valid_o, fetch_gnt_o, fetch_rd_valid_o;
  logic [31:0] rd_data_o, mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic        mem_en_o;
  logic [3:0]  mem_wr_byte_en_o;

  always #5 clk_i = ~clk_i;

  ram_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .dbg_req_i         (dbg_req_i),
    .dbg_addr_i        (dbg_addr_i),
    .dbg_wr_data_i     (dbg_wr_data_i),
    .dbg_wr_byte_en_i  (dbg_wr_byte_en_i),
    .dbg_gnt_o         (dbg_gnt_o),
    .dbg_rd_valid_o    (dbg_rd_valid_o),
    .dbg_lock_i        (dbg_lock_i),
    .dbg_lock_ack_o    (dbg_lock_ack_o),
    .data_req_i        (data_req_i),
    .data_addr_i       (data_addr_i),
    .data_wr_data_i    (data_wr_data_i),
    .data_wr_byte_en_i (data_wr_byte_en_i),
    .data_gnt_o        (data_gnt_o),
    .data_rd_valid_o   (data_rd_valid_o),
    .fetch_req_i       (fetch_req_i),
    .fetch_addr_i      (fetch_addr_i),
    .fetch_gnt_o       (fetch_gnt_o),
    .fetch_rd_valid_o  (fetch_rd_valid_o),
    .rd_data_o         (rd_data_o),
    .mem_en_o          (mem_en_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wr_data_o     (mem_wr_data_o),
    .mem_wr_byte_en_o  (mem_wr_byte_en_o),
    .mem_rd_data_i     (mem_rd_data_i)
  );

  // One cycle of stimulus plus the outputs expected in that cycle.
  // gnt / vld bit order: {fetch, data, dbg}.
  typedef struct packed {
    logic        dreq;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        qreq;
    logic [31:0] qaddr;
    logic [31:0] qwd;
    logic [3:0]  qbe;
    logic        freq;
    logic [31:0] faddr;
    logic        lock;
    logic [31:0] mrd;
    logic [2:0]  gnt;
    logic [2:0]  vld;
    logic        ack;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mbe;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    dbg_req_i = 1'b0; dbg_addr_i = '0; dbg_wr_data_i = '0; dbg_wr_byte_en_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_wr_data_i = '0; data_wr_byte_en_i = '0;
    fetch_req_i = 1'b0; fetch_addr_i = '0; dbg_lock_i = 1'b0; mem_rd_data_i = '0;
  endtask

  task automatic apply(input vec_t v);
    dbg_req_i = v.dreq; dbg_addr_i = v.daddr; dbg_wr_data_i = v.dwd; dbg_wr_byte_en_i = v.dbe;
    data_req_i = v.qreq; data_addr_i = v.qaddr; data_wr_data_i = v.qwd; data_wr_byte_en_i = v.qbe;
    fetch_req_i = v.freq; fetch_addr_i = v.faddr; dbg_lock_i = v.lock; mem_rd_data_i = v.mrd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, ".gnt"},   32'({fetch_gnt_o, data_gnt_o, dbg_gnt_o}), 32'(v.gnt));
    chk({t, ".vld"},   32'({fetch_rd_valid_o, data_rd_valid_o, dbg_rd_valid_o}), 32'(v.vld));
    chk({t, ".en"},    32'(mem_en_o), 32'(|v.gnt));
    chk({t, ".addr"},  mem_addr_o, v.maddr);
    chk({t, ".wdata"}, mem_wr_data_o, v.mwd);
    chk({t, ".be"},    32'(mem_wr_byte_en_o), 32'(v.mbe));
    chk({t, ".ack"},   32'(dbg_lock_ack_o), 32'(v.ack));
    if (v.vld != 3'b000) chk({t, ".rdata"}, rd_data_o, v.mrd);
  endtask

  task automatic build_table();
    vec_t v;
    // 0: idle after reset
    v = '0; vt.push_back(v);
    // 1: fetch read 0x100
    v = '0; v.freq = 1'b1; v.faddr = 32'h100; v.gnt = 3'b100; v.maddr = 32'h100; vt.push_back(v);
    // 2: fetch data returns
    v = '0; v.mrd = 32'h0000_0013; v.vld = 3'b100; vt.push_back(v);
    // 3: data write beats fetch
    v = '0; v.qreq = 1'b1; v.qaddr = 32'h2000; v.qwd = 32'hDEAD_BEEF; v.qbe = 4'b0011;
    v.freq = 1'b1; v.faddr = 32'h104;
    v.gnt = 3'b010; v.maddr = 32'h2000; v.mwd = 32'hDEAD_BEEF; v.mbe = 4'b0011; vt.push_back(v);
    // 4: no read return after a write
    v = '0; v.mrd = 32'hFFFF_FFFF; vt.push_back(v);
    // 5: all three request, dbg wins
    v = '0; v.dreq = 1'b1; v.daddr = 32'h40; v.qreq = 1'b1; v.qaddr = 32'h80;
    v.freq = 1'b1; v.faddr = 32'h108; v.gnt = 3'b001; v.maddr = 32'h40; vt.push_back(v);
    // 6: data over fetch, dbg read returns
    v = '0; v.qreq = 1'b1; v.qaddr = 32'h80; v.freq = 1'b1; v.faddr = 32'h108;
    v.mrd = 32'hAAAA_0001; v.gnt = 3'b010; v.vld = 3'b001; v.maddr = 32'h80; vt.push_back(v);
    // 7: fetch alone, data read returns
    v = '0; v.freq = 1'b1; v.faddr = 32'h108; v.mrd = 32'hBBBB_0002;
    v.gnt = 3'b100; v.vld = 3'b010; v.maddr = 32'h108; vt.push_back(v);
    // 8: idle, fetch read returns
    v = '0; v.mrd = 32'hCCCC_0003; v.vld = 3'b100; vt.push_back(v);
    // 9..14: data and fetch held; fetch promoted on the fifth cycle
    for (int c = 0; c < 6; c++) begin
      v = '0; v.qreq = 1'b1; v.qaddr = 32'h300; v.freq = 1'b1; v.faddr = 32'h400;
      v.mrd = 32'h5000_0000 + 32'(c);
      if (c == 4) begin v.gnt = 3'b100; v.maddr = 32'h400; end
      else        begin v.gnt = 3'b010; v.maddr = 32'h300; end
      if (c == 0)      v.vld = 3'b000;
      else if (c == 5) v.vld = 3'b100;
      else             v.vld = 3'b010;
      vt.push_back(v);
    end
    // 15: idle, last data read returns
    v = '0; v.mrd = 32'h5000_0006; v.vld = 3'b010; vt.push_back(v);
    // 16: lock raised while fetching; this cycle still arbitrates
    v = '0; v.lock = 1'b1; v.freq = 1'b1; v.faddr = 32'h500; v.gnt = 3'b100; v.maddr = 32'h500; vt.push_back(v);
    // 17: DRAIN, no grants, fetch read returns
    v = '0; v.lock = 1'b1; v.freq = 1'b1; v.faddr = 32'h504; v.mrd = 32'h0000_AAAA; v.vld = 3'b100; vt.push_back(v);
    // 18: LOCKED, fetch denied
    v = '0; v.lock = 1'b1; v.freq = 1'b1; v.faddr = 32'h504; v.ack = 1'b1; vt.push_back(v);
    // 19: LOCKED, dbg write granted
    v = '0; v.lock = 1'b1; v.freq = 1'b1; v.faddr = 32'h504;
    v.dreq = 1'b1; v.daddr = 32'h0; v.dwd = 32'h1234_5678; v.dbe = 4'b1111;
    v.gnt = 3'b001; v.maddr = 32'h0; v.mwd = 32'h1234_5678; v.mbe = 4'b1111; v.ack = 1'b1; vt.push_back(v);
    // 20: LOCKED, dbg read granted
    v = '0; v.lock = 1'b1; v.freq = 1'b1; v.faddr = 32'h504; v.dreq = 1'b1; v.daddr = 32'h4;
    v.gnt = 3'b001; v.maddr = 32'h4; v.ack = 1'b1; vt.push_back(v);
    // 21: lock drops together with a dbg access, which is still granted
    v = '0; v.freq = 1'b1; v.faddr = 32'h504; v.dreq = 1'b1; v.daddr = 32'h8; v.mrd = 32'h1111_0004;
    v.gnt = 3'b001; v.vld = 3'b001; v.maddr = 32'h8; v.ack = 1'b1; vt.push_back(v);
    // 22: back in RUN, fetch granted
    v = '0; v.freq = 1'b1; v.faddr = 32'h504; v.mrd = 32'h2222_0008;
    v.gnt = 3'b100; v.vld = 3'b001; v.maddr = 32'h504; vt.push_back(v);
    // 23: idle, fetch read returns
    v = '0; v.mrd = 32'h3333_0504; v.vld = 3'b100; vt.push_back(v);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n_i = 1'b0;
    build_table();

    // Reset state
    #2;
    chk("rst.gnt", 32'({fetch_gnt_o, data_gnt_o, dbg_gnt_o}), 32'h0);
    chk("rst.vld", 32'({fetch_rd_valid_o, data_rd_valid_o, dbg_rd_valid_o}), 32'h0);
    chk("rst.en",  32'(mem_en_o), 32'h0);
    chk("rst.be",  32'(mem_wr_byte_en_o), 32'h0);
    chk("rst.ack", 32'(dbg_lock_ack_o), 32'h0);
    #10 rst_n_i = 1'b1;

    // Table-driven cycles
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk_i); #1;
      apply(vt[i]);
      #3;
      check_vec(i, vt[i]);
    end

    // Reset asserted right after a data read grant: no read return
    @(posedge clk_i); #1;
    clear_inputs();
    data_req_i = 1'b1; data_addr_i = 32'h700;
    #3;
    chk("rstrd.gnt", 32'(data_gnt_o), 32'h1);
    #2;
    rst_n_i = 1'b0; data_req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rstrd.vld0", 32'(data_rd_valid_o), 32'h0);
    #3;
    chk("rstrd.vld1", 32'(data_rd_valid_o), 32'h0);
    rst_n_i = 1'b1;

    // Reset while LOCKED returns the FSM to RUN
    @(posedge clk_i); #1;
    dbg_lock_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    chk("rstlk.ack", 32'(dbg_lock_ack_o), 32'h1);
    fetch_req_i = 1'b1; fetch_addr_i = 32'h900;
    #2;
    chk("rstlk.fdeny", 32'(fetch_gnt_o), 32'h0);
    rst_n_i = 1'b0;
    #1;
    chk("rstlk.ack0", 32'(dbg_lock_ack_o), 32'h0);
    dbg_lock_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rstlk.fgnt", 32'(fetch_gnt_o), 32'h1);
    chk("rstlk.addr", mem_addr_o, 32'h900);
    chk("rstlk.ack1", 32'(dbg_lock_ack_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
